// File: rtl/even_odd_seq_checker.sv
// Receive-side checker for the even/odd step-by-2 counter: verifies parity and +2 stepping,
// locks after LOCK_CNT good steps and flags breaks. Optional sticky error flag: EOC_STICKY_ERR_EN.
module even_odd_seq_checker #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned LOCK_CNT  = 2,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     count_in,
  input  logic                 resync,
`ifdef EOC_STICKY_ERR_EN
  input  logic                 clr_err,
  output logic                 err_sticky,
`endif
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     expected
);

  localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  state_t               state, state_n;
  logic [GOOD_W-1:0]    good, good_n, good_inc;
  logic [WIDTH-1:0]     expected_n, next_val;
  logic [ERR_CNT_W-1:0] err_count_n, err_base;
  logic                 locked_n, err_n;
  logic                 mode_q, resync_pend, resync_pend_n;
  logic                 parity_ok, match, mode_chg, resync_eff;

  // Next-state and output computation
  always_comb begin
    state_n       = state;
    good_n        = good;
    expected_n    = expected;
    resync_pend_n = resync_pend;
    err_n         = 1'b0;
    next_val      = count_in + WIDTH'(2);
    good_inc      = good + GOOD_W'(1);
    parity_ok     = (count_in[0] == mode);
    match         = (count_in == expected);
    mode_chg      = (mode != mode_q);
    resync_eff    = resync | resync_pend;

    if (mode_chg) begin
      // Sample coinciding with a mode change is dropped.
      state_n       = IDLE;
      good_n        = '0;
      resync_pend_n = 1'b0;
    end else if (valid && (resync_eff || state == IDLE)) begin
      resync_pend_n = 1'b0;
      good_n        = '0;
      if (parity_ok) begin
        state_n    = ACQUIRE;
        expected_n = next_val;
      end else begin
        state_n    = IDLE;
      end
    end else if (valid) begin
      case (state)
        ACQUIRE: begin
          if (match) begin
            good_n     = good_inc;
            expected_n = next_val;
            if (good_inc == GOOD_W'(LOCK_CNT)) state_n = LOCKED;
          end else if (parity_ok) begin
            good_n     = '0;
            expected_n = next_val;
          end else begin
            good_n     = '0;
            state_n    = IDLE;
          end
        end
        LOCKED: begin
          if (match) begin
            expected_n = next_val;
          end else begin
            err_n  = 1'b1;
            good_n = '0;
            if (parity_ok) begin
              state_n    = ACQUIRE;
              expected_n = next_val;
            end else begin
              state_n    = IDLE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end else if (resync) begin
      resync_pend_n = 1'b1;
    end

`ifdef EOC_STICKY_ERR_EN
    err_base = clr_err ? '0 : err_count;
`else
    err_base = err_count;
`endif
    err_count_n = err_base;
    if (err_n && (err_base != {ERR_CNT_W{1'b1}})) err_count_n = err_base + ERR_CNT_W'(1);

    locked_n = (state_n == LOCKED);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    mode_q <= mode;
    if (rst) begin
      state       <= IDLE;
      good        <= '0;
      expected    <= '0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      err_count   <= '0;
      resync_pend <= 1'b0;
    end else begin
      state       <= state_n;
      good        <= good_n;
      expected    <= expected_n;
      locked      <= locked_n;
      err_pulse   <= err_n;
      err_count   <= err_count_n;
      resync_pend <= resync_pend_n;
    end
  end

`ifdef EOC_STICKY_ERR_EN
  // Sticky flag: a new error beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst)          err_sticky <= 1'b0;
    else if (err_n)   err_sticky <= 1'b1;
    else if (clr_err) err_sticky <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_even_odd_seq_checker.sv
// Directed self-checking bench for even_odd_seq_checker (default instance plus a 2-bit error counter instance).
module tb_even_odd_seq_checker;

  logic       clk = 1'b0;
  logic       rst, valid, mode, resync;
  logic [3:0] count_in;
  logic       locked, err_pulse, locked2, err_pulse2;
  logic [7:0] err_count;
  logic [1:0] err_count2;
  logic [3:0] expected, expected2;
`ifdef EOC_STICKY_ERR_EN
  logic       clr_err, err_sticky, err_sticky2;
`endif

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  even_odd_seq_checker #(.WIDTH(4), .LOCK_CNT(2), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .valid(valid), .mode(mode), .count_in(count_in), .resync(resync),
`ifdef EOC_STICKY_ERR_EN
    .clr_err(clr_err), .err_sticky(err_sticky),
`endif
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .expected(expected)
  );

  even_odd_seq_checker #(.WIDTH(4), .LOCK_CNT(2), .ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .valid(valid), .mode(mode), .count_in(count_in), .resync(resync),
`ifdef EOC_STICKY_ERR_EN
    .clr_err(clr_err), .err_sticky(err_sticky2),
`endif
    .locked(locked2), .err_pulse(err_pulse2), .err_count(err_count2), .expected(expected2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One valid sample; outputs are observed just after the consuming edge.
  task automatic smp(input logic [3:0] v);
    valid    = 1'b1;
    count_in = v;
    tick();
    valid    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; mode = 1'b0; resync = 1'b0; count_in = '0;
`ifdef EOC_STICKY_ERR_EN
    clr_err = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    check("rst_locked", 32'(locked), 0);
    check("rst_err_pulse", 32'(err_pulse), 0);
    check("rst_err_count", 32'(err_count), 0);
    check("rst_expected", 32'(expected), 0);

    // Even acquire and lock on 0,2,4
    smp(0); check("acq_exp0", 32'(expected), 2); check("acq_lock0", 32'(locked), 0);
    smp(2); check("acq_lock2", 32'(locked), 0);
    smp(4); check("lock_after4", 32'(locked), 1); check("exp_after4", 32'(expected), 6);
    check("errcnt_after4", 32'(err_count), 0);

    // Locked break with bad parity -> IDLE
    smp(6); check("exp_after6", 32'(expected), 8);
    smp(9);
    check("brk_pulse", 32'(err_pulse), 1); check("brk_count", 32'(err_count), 1);
    check("brk_locked", 32'(locked), 0); check("brk_exp_hold", 32'(expected), 8);
    tick(); check("brk_pulse_one", 32'(err_pulse), 0);
    // From IDLE, 8 only seeds, so 8,10 is not yet enough to lock
    smp(8); smp(10); check("idle_proof", 32'(locked), 0);
    smp(12); check("relock_even", 32'(locked), 1);

    // Odd sequence across the wrap
    mode = 1'b1; tick(); check("modechg_unlock", 32'(locked), 0);
    smp(11); check("odd_exp13", 32'(expected), 13);
    smp(13);
    smp(15); check("odd_lock", 32'(locked), 1); check("odd_wrap_exp", 32'(expected), 1);
    smp(1);  check("wrap_no_err", 32'(err_pulse), 0); check("wrap_exp", 32'(expected), 3);
    smp(3);  check("odd_exp5", 32'(expected), 5); check("odd_still_lock", 32'(locked), 1);
    check("odd_errcnt", 32'(err_count), 1);

    // Resync while locked at expected 8
    mode = 1'b0; tick();
    smp(2); smp(4); smp(6); check("pre_resync_exp", 32'(expected), 8);
    resync = 1'b1; smp(2); resync = 1'b0;
    check("resync_pulse", 32'(err_pulse), 0); check("resync_locked", 32'(locked), 0);
    check("resync_exp", 32'(expected), 4);
    smp(4); check("resync_lock4", 32'(locked), 0);
    smp(6); check("resync_relock", 32'(locked), 1);

    // Pending resync: held until the next valid sample
    resync = 1'b1; tick(); resync = 1'b0;
    check("pend_hold_lock", 32'(locked), 1);
    smp(0);
    check("pend_pulse", 32'(err_pulse), 0); check("pend_locked", 32'(locked), 0);
    check("pend_exp", 32'(expected), 2); check("pend_errcnt", 32'(err_count), 1);

    // Mode change with a coincident sample: sample ignored
    smp(2); smp(4); check("lock_before_mode", 32'(locked), 1);
    mode = 1'b1; smp(6);
    check("mode_unlock", 32'(locked), 0); check("mode_ignore_exp", 32'(expected), 6);
    check("mode_errcnt", 32'(err_count), 1);

    // Reset mid-ACQUIRE
    smp(7); check("acq_odd_exp", 32'(expected), 9);
    rst = 1'b1; tick();
    check("midrst_exp", 32'(expected), 0); check("midrst_errcnt", 32'(err_count), 0);
    check("midrst_locked", 32'(locked), 0); check("midrst_pulse", 32'(err_pulse), 0);
    rst = 1'b0; mode = 1'b0; tick();

    // Four locked breaks: 2-bit counter saturates at 3
    for (int i = 0; i < 4; i++) begin
      smp(0); smp(2); smp(4);
      check("sat_locked", 32'(locked2), 1);
      smp(9);
      check("sat_pulse", 32'(err_pulse2), 1);
      check("sat_count2", 32'(err_count2), (i < 3) ? i + 1 : 3);
      check("sat_count8", 32'(err_count), i + 1);
    end
    tick(); check("sat_pulse_low", 32'(err_pulse2), 0); check("sat_final", 32'(err_count2), 3);

`ifdef EOC_STICKY_ERR_EN
    check("sticky_set", 32'(err_sticky), 1); check("sticky_set2", 32'(err_sticky2), 1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("sticky_clr", 32'(err_sticky), 0); check("clr_count", 32'(err_count), 0);
    check("clr_count2", 32'(err_count2), 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/even_odd_seq_checker.md
Name: even_odd_seq_checker

Overview:
Receive-side companion to the team's even/odd step-by-2 counter. Samples the counter's output stream and checks two things: every sample has the parity selected by mode, and each sample equals the previous one + 2 (mod 2^WIDTH). It locks after a run of good steps, then flags any break in the sequence with a pulse and a saturating error counter. It sits on the consumer side of the counter bus, in the test or monitor path.

Parameters:
WIDTH, 4, width of count_in and expected
LOCK_CNT, 2, consecutive correct +2 steps required to enter LOCKED (min 1)
ERR_CNT_W, 8, width of saturating error counter

Ports:
clk  input  1  clock, rising-edge
rst  input  1  reset, synchronous, active-high
valid  input  1  count_in qualifier; sample consumed on rising clk when high
mode  input  1  0 = even sequence, 1 = odd sequence
count_in  input  WIDTH  observed counter value
resync  input  1  source was loaded; the next valid sample becomes the new seed without error
locked  output  1  checker is in LOCKED state
err_pulse  output  1  one-cycle pulse on a sequence/parity break while LOCKED
err_count  output  ERR_CNT_W  saturating count of err_pulse events
expected  output  WIDTH  next value predicted by the checker

Behaviour:
- All outputs are registered. Responses appear the cycle after the sampling edge.
- Reset: state=IDLE, locked=0, err_pulse=0, err_count=0, expected=0, good=0. rst has priority over every other input.
- Parity check: parity_ok = (count_in[0] == mode).
- Arithmetic: expected <= count_in + 2, truncated to WIDTH bits. Wrap is legal: WIDTH=4, 14 -> 0 and 15 -> 1.
- Internal good counter: width clog2(LOCK_CNT+1).
- FSM states: IDLE, ACQUIRE, LOCKED.
- IDLE:
  - valid & parity_ok -> ACQUIRE, expected = count_in + 2, good = 0.
  - Otherwise stay in IDLE.
- ACQUIRE, on valid:
  - count_in == expected (this implies parity_ok): good++, expected = count_in + 2. When good reaches LOCK_CNT -> LOCKED, locked = 1.
  - Mismatch with parity_ok: re-seed from count_in, good = 0, stay in ACQUIRE.
  - Mismatch with bad parity: -> IDLE.
  - No error is ever reported in ACQUIRE.
- LOCKED, on valid:
  - Match: expected += 2.
  - Mismatch: err_pulse = 1 for exactly one cycle, err_count++ (saturates at all-ones), locked = 0. Next state is ACQUIRE seeded from count_in if parity_ok, else IDLE.
- valid low: state, expected and good hold. err_pulse = 0.
- resync high with valid (any state): treat the sample as a fresh seed, with the same rules as IDLE. No err_pulse, locked drops to 0. resync without valid is held pending until the next valid sample.
- mode changes (mode != mode registered at the last edge): -> IDLE, locked = 0, good = 0, no error. If a valid sample coincides with the change, it is ignored.
- Precedence: rst > mode change > resync > normal FSM.
- Reset mid-operation returns everything to reset values at that edge.

Optional Feature:
Macro EOC_STICKY_ERR_EN.
- Defined: adds input clr_err (1) and output err_sticky (1).
  - err_sticky is set on any err_pulse and held until clr_err is high at a clock edge.
  - If set and clear occur in the same cycle, set wins.
  - clr_err also zeroes err_count. Reset value is 0.
- Undefined: neither port exists. err_count clears only on rst.

Test Plan:
- WIDTH=4, LOCK_CNT=2, mode=0, valid samples 0,2,4 -> locked=1 one cycle after sample 4, expected=6, err_count=0.
- Locked even sequence at expected=6; samples 6 then 9 -> after 9: err_pulse=1 for one cycle, err_count=1, locked=0, state IDLE (9 fails even parity).
- mode=1, samples 11,13,15,1,3 -> locked after 15, no err_pulse across the wrap, expected=5 after 3.
- Locked with expected=8; resync=1 with valid sample 2 -> no err_pulse, locked=0, expected=4. Samples 4,6 -> locked=1 again.
- Locked even; toggle mode to 1 -> locked=0, state IDLE, err_count unchanged. rst asserted mid-ACQUIRE -> all outputs 0 next cycle.
- ERR_CNT_W=2: force 4 locked-state mismatches (re-lock between each) -> err_count=3, saturated. With EOC_STICKY_ERR_EN: err_sticky=1 until clr_err, then err_sticky=0 and err_count=0.
